// File: rtl/riscv_regfile_pkg.sv
// Sizing helpers and port-count limits shared by the multi-port RI5CY register file.
package riscv_regfile_pkg;

   localparam int unsigned MAX_READ_PORTS  = 4;
   localparam int unsigned MAX_WRITE_PORTS = 3;

   // Separate FP storage exists only with an FPU that is not in Zfinx mode
   function automatic bit has_fp_bank(input int unsigned fpu, input int unsigned zfinx);
      return (fpu != 0) && (zfinx == 0);
   endfunction

   function automatic int unsigned num_tot_words(input int unsigned addr_width,
                                                 input int unsigned fpu,
                                                 input int unsigned zfinx);
      int unsigned nw;
      nw = 32'd1 << (addr_width - 1);
      return has_fp_bank(fpu, zfinx) ? (nw << 1) : nw;
   endfunction

   function automatic int unsigned sel_width(input int unsigned num_ports);
      return (num_ports > 1) ? $clog2(num_ports) : 1;
   endfunction

endpackage

// File: rtl/cluster_clock_gating.sv
// Latch-based clock gate: enable is captured while the clock is low.
module cluster_clock_gating (
   input  logic clk_i,
   input  logic en_i,
   input  logic test_en_i,
   output logic clk_o
);

   logic clk_en;

   always_latch begin
      if (clk_i == 1'b0) clk_en <= en_i | test_en_i;
   end

   assign clk_o = clk_i & clk_en;

endmodule

// File: rtl/riscv_regfile_wdec.sv
// Write-address decoder: one-hot per port, merged so the highest enabled port owns each word.
module riscv_regfile_wdec #(
   parameter int unsigned NUM_WRITE = 2,
   parameter int unsigned NUM_WORDS = 32,
   parameter int unsigned IDX_W     = 5,
   parameter int unsigned SEL_W     = 1
) (
   input  logic [IDX_W-1:0]     widx [NUM_WRITE],
   input  logic [NUM_WRITE-1:0] we,
   output logic [NUM_WORDS-1:0] word_we_c,
   output logic [SEL_W-1:0]     word_sel_c [NUM_WORDS]
);

   logic [NUM_WORDS-1:0] port_hot [NUM_WRITE];

   // Word 0 is always x0 and never accepts a write
   always_comb begin
      for (int p = 0; p < NUM_WRITE; p++) begin
         port_hot[p] = '0;
         if (we[p]) port_hot[p][widx[p]] = 1'b1;
         port_hot[p][0] = 1'b0;
      end
   end

   always_comb begin
      word_we_c = '0;
      for (int w = 0; w < NUM_WORDS; w++) word_sel_c[w] = '0;
      for (int p = 0; p < NUM_WRITE; p++) begin
         for (int w = 0; w < NUM_WORDS; w++) begin
            if (port_hot[p][w]) begin
               word_we_c[w]  = 1'b1;
               word_sel_c[w] = SEL_W'(p);
            end
         end
      end
   end

endmodule

// File: rtl/riscv_register_file_mp.sv
// Multi-port flip-flop register file: integer bank, optional FP bank, optional write bypass,
// per-word clock gating and dirty flags for lazy context save.
module riscv_register_file_mp
   import riscv_regfile_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_READ   = 3,
   parameter int unsigned NUM_WRITE  = 2,
   parameter int unsigned FPU        = 0,
   parameter int unsigned ZFINX      = 0,
   parameter int unsigned BYPASS     = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  test_en_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i [NUM_READ],
   output logic [DATA_WIDTH-1:0] rdata_o [NUM_READ],
   input  logic [ADDR_WIDTH-1:0] waddr_i [NUM_WRITE],
   input  logic [DATA_WIDTH-1:0] wdata_i [NUM_WRITE],
   input  logic [NUM_WRITE-1:0]  we_i,
   output logic [num_tot_words(ADDR_WIDTH, FPU, ZFINX)-1:0] dirty_o,
   input  logic                  dirty_clr_i
);

   localparam int unsigned NUM_TOT_WORDS = num_tot_words(ADDR_WIDTH, FPU, ZFINX);
   localparam bit          HAS_FP        = has_fp_bank(FPU, ZFINX);
   localparam int unsigned IDX_W         = HAS_FP ? ADDR_WIDTH : ADDR_WIDTH - 1;
   localparam int unsigned SEL_W         = sel_width(NUM_WRITE);
   // Without an FP bank the bank-select MSB is dropped so both halves alias the integer bank
   localparam logic [ADDR_WIDTH-1:0] ADDR_MASK =
      HAS_FP ? '1 : ADDR_WIDTH'({(ADDR_WIDTH-1){1'b1}});

   if (NUM_READ < 1 || NUM_READ > MAX_READ_PORTS ||
       NUM_WRITE < 1 || NUM_WRITE > MAX_WRITE_PORTS) begin : g_bad_cfg
      $error("riscv_register_file_mp: unsupported port count");
   end

   function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
      return IDX_W'(addr & ADDR_MASK);
   endfunction

   logic [IDX_W-1:0]      widx     [NUM_WRITE];
   logic [IDX_W-1:0]      ridx     [NUM_READ];
   logic [NUM_TOT_WORDS-1:0] word_we;
   logic [SEL_W-1:0]      word_sel [NUM_TOT_WORDS];
   logic [DATA_WIDTH-1:0] rf       [NUM_TOT_WORDS];
   logic [NUM_TOT_WORDS-1:0] dirty_q;
   logic                  clk_int;

   always_comb begin
      for (int w = 0; w < NUM_WRITE; w++) widx[w] = word_idx(waddr_i[w]);
      for (int r = 0; r < NUM_READ; r++)  ridx[r] = word_idx(raddr_i[r]);
   end

   riscv_regfile_wdec #(
      .NUM_WRITE (NUM_WRITE),
      .NUM_WORDS (NUM_TOT_WORDS),
      .IDX_W     (IDX_W),
      .SEL_W     (SEL_W)
   ) u_wdec (
      .widx       (widx),
      .we         (we_i),
      .word_we_c  (word_we),
      .word_sel_c (word_sel)
   );

   cluster_clock_gating u_gate_global (
      .clk_i     (clk),
      .en_i      (|we_i),
      .test_en_i (test_en_i),
      .clk_o     (clk_int)
   );

   for (genvar i = 0; i < NUM_TOT_WORDS; i++) begin : g_word
      if (i == 0) begin : g_zero
         assign rf[i] = '0;
      end else begin : g_reg
         logic                  clk_word;
         logic [DATA_WIDTH-1:0] q;

         cluster_clock_gating u_gate (
            .clk_i     (clk_int),
            .en_i      (word_we[i]),
            .test_en_i (test_en_i),
            .clk_o     (clk_word)
         );

         always_ff @(posedge clk_word or negedge rst_n) begin
            if (!rst_n) q <= '0;
            else        q <= wdata_i[word_sel[i]];
         end

         assign rf[i] = q;
      end
   end

   // Bypass follows the same highest-port-wins order as the storage write
   always_comb begin
      for (int r = 0; r < NUM_READ; r++) begin
         rdata_o[r] = rf[ridx[r]];
         if (BYPASS != 0 && ridx[r] != '0) begin
            for (int w = 0; w < NUM_WRITE; w++) begin
               if (we_i[w] && widx[w] == ridx[r]) rdata_o[r] = wdata_i[w];
            end
         end
      end
   end

   // Set wins over clear so a write coincident with the clear stays marked
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dirty_q <= '0;
      else        dirty_q <= (dirty_clr_i ? '0 : dirty_q) | word_we;
   end

   assign dirty_o = dirty_q;

endmodule

// File: tb/tb_riscv_register_file_mp.sv
// Directed bench: three configurations (FP bank, integer-only with bypass, Zfinx) share stimulus.
module tb_riscv_register_file_mp;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        test_en;
   logic        dirty_clr;
   logic [5:0]  raddr [3];
   logic [5:0]  waddr [2];
   logic [31:0] wdata [2];
   logic [1:0]  we;

   logic [31:0] rdata_a [3];
   logic [31:0] rdata_b [3];
   logic [31:0] rdata_c [3];
   logic [63:0] dirty_a;
   logic [31:0] dirty_b;
   logic [31:0] dirty_c;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   riscv_register_file_mp #(.FPU(1), .ZFINX(0), .BYPASS(0)) dut_fp (
      .clk(clk), .rst_n(rst_n), .test_en_i(test_en),
      .raddr_i(raddr), .rdata_o(rdata_a),
      .waddr_i(waddr), .wdata_i(wdata), .we_i(we),
      .dirty_o(dirty_a), .dirty_clr_i(dirty_clr)
   );

   riscv_register_file_mp #(.FPU(0), .ZFINX(0), .BYPASS(1)) dut_byp (
      .clk(clk), .rst_n(rst_n), .test_en_i(test_en),
      .raddr_i(raddr), .rdata_o(rdata_b),
      .waddr_i(waddr), .wdata_i(wdata), .we_i(we),
      .dirty_o(dirty_b), .dirty_clr_i(dirty_clr)
   );

   riscv_register_file_mp #(.FPU(1), .ZFINX(1), .BYPASS(0)) dut_zx (
      .clk(clk), .rst_n(rst_n), .test_en_i(test_en),
      .raddr_i(raddr), .rdata_o(rdata_c),
      .waddr_i(waddr), .wdata_i(wdata), .we_i(we),
      .dirty_o(dirty_c), .dirty_clr_i(dirty_clr)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic go_idle();
      @(negedge clk);
      we        = 2'b00;
      dirty_clr = 1'b0;
      #1;
   endtask

   task automatic edge_sample();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      test_en   = 1'b0;
      dirty_clr = 1'b0;
      we        = 2'b00;
      for (int i = 0; i < 3; i++) raddr[i] = '0;
      for (int i = 0; i < 2; i++) begin
         waddr[i] = '0;
         wdata[i] = '0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;

      // Reset state across the whole address space
      check_eq("rst_dirty_a", dirty_a, 64'h0);
      check_eq("rst_dirty_b", {32'h0, dirty_b}, 64'h0);
      check_eq("rst_dirty_c", {32'h0, dirty_c}, 64'h0);
      for (int a = 0; a < 64; a++) begin
         raddr[0] = 6'(a);
         raddr[1] = 6'(63 - a);
         raddr[2] = 6'((a + 17) % 64);
         #1;
         for (int p = 0; p < 3; p++) begin
            check_eq($sformatf("rst_a_p%0d_%0d", p, a), {32'h0, rdata_a[p]}, 64'h0);
            check_eq($sformatf("rst_b_p%0d_%0d", p, a), {32'h0, rdata_b[p]}, 64'h0);
            check_eq($sformatf("rst_c_p%0d_%0d", p, a), {32'h0, rdata_c[p]}, 64'h0);
         end
      end

      // x5 write: same-cycle read shows old value unless bypassed
      @(negedge clk);
      raddr[0] = 6'd5; raddr[1] = 6'd6; raddr[2] = 6'd0;
      waddr[0] = 6'd5; wdata[0] = 32'hDEADBEEF;
      waddr[1] = 6'd0; wdata[1] = 32'h0;
      we = 2'b01;
      #1;
      check_eq("x5_same_a", {32'h0, rdata_a[0]}, 64'h0);
      check_eq("x5_same_b", {32'h0, rdata_b[0]}, 64'hDEADBEEF);
      check_eq("x5_same_c", {32'h0, rdata_c[0]}, 64'h0);
      check_eq("x6_same_b", {32'h0, rdata_b[1]}, 64'h0);
      edge_sample();
      check_eq("x5_next_a", {32'h0, rdata_a[0]}, 64'hDEADBEEF);
      check_eq("x5_next_b", {32'h0, rdata_b[0]}, 64'hDEADBEEF);
      check_eq("x5_next_c", {32'h0, rdata_c[0]}, 64'hDEADBEEF);
      go_idle();
      check_eq("x5_dirty_a", dirty_a, 64'h20);
      check_eq("x5_dirty_b", {32'h0, dirty_b}, 64'h20);
      check_eq("x5_dirty_c", {32'h0, dirty_c}, 64'h20);

      // Collision on x7: port 1 wins
      @(negedge clk);
      raddr[0] = 6'd7;
      waddr[0] = 6'd7; wdata[0] = 32'h1111;
      waddr[1] = 6'd7; wdata[1] = 32'h2222;
      we = 2'b11;
      #1;
      check_eq("x7_same_a", {32'h0, rdata_a[0]}, 64'h0);
      check_eq("x7_same_b", {32'h0, rdata_b[0]}, 64'h2222);
      edge_sample();
      check_eq("x7_next_a", {32'h0, rdata_a[0]}, 64'h2222);
      check_eq("x7_next_b", {32'h0, rdata_b[0]}, 64'h2222);
      check_eq("x7_next_c", {32'h0, rdata_c[0]}, 64'h2222);
      go_idle();
      check_eq("x7_dirty_a", dirty_a, 64'hA0);

      // x0 write is discarded and never marks dirty
      @(negedge clk);
      raddr[0] = 6'd0;
      waddr[0] = 6'd0; wdata[0] = 32'hFFFFFFFF;
      we = 2'b01;
      #1;
      check_eq("x0_same_b", {32'h0, rdata_b[0]}, 64'h0);
      edge_sample();
      check_eq("x0_next_a", {32'h0, rdata_a[0]}, 64'h0);
      check_eq("x0_next_b", {32'h0, rdata_b[0]}, 64'h0);
      check_eq("x0_next_c", {32'h0, rdata_c[0]}, 64'h0);
      go_idle();
      check_eq("x0_dirty_a", dirty_a, 64'hA0);
      check_eq("x0_dirty_b", {32'h0, dirty_b}, 64'hA0);

      // Address 0x21: f1 with an FP bank, aliases x1 otherwise
      @(negedge clk);
      raddr[0] = 6'h21; raddr[1] = 6'h01;
      waddr[1] = 6'h21; wdata[1] = 32'hA5A5A5A5;
      we = 2'b10;
      #1;
      check_eq("f1_same_b_alias", {32'h0, rdata_b[1]}, 64'hA5A5A5A5);
      check_eq("f1_same_a", {32'h0, rdata_a[0]}, 64'h0);
      edge_sample();
      check_eq("f1_next_a", {32'h0, rdata_a[0]}, 64'hA5A5A5A5);
      check_eq("x1_next_a", {32'h0, rdata_a[1]}, 64'h0);
      check_eq("x1_next_b", {32'h0, rdata_b[1]}, 64'hA5A5A5A5);
      check_eq("x1_next_c", {32'h0, rdata_c[1]}, 64'hA5A5A5A5);
      check_eq("f1_next_c", {32'h0, rdata_c[0]}, 64'hA5A5A5A5);
      go_idle();
      check_eq("f1_dirty_a", dirty_a, 64'h0000_0002_0000_00A0);
      check_eq("f1_dirty_b", {32'h0, dirty_b}, 64'hA2);
      check_eq("f1_dirty_c", {32'h0, dirty_c}, 64'hA2);

      // f0 is an ordinary FP register; without FP bank it aliases x0
      @(negedge clk);
      raddr[0] = 6'h20; raddr[1] = 6'h00;
      waddr[0] = 6'h20; wdata[0] = 32'h12345678;
      we = 2'b01;
      #1;
      check_eq("f0_same_b", {32'h0, rdata_b[0]}, 64'h0);
      edge_sample();
      check_eq("f0_next_a", {32'h0, rdata_a[0]}, 64'h12345678);
      check_eq("x0_after_f0_a", {32'h0, rdata_a[1]}, 64'h0);
      check_eq("f0_next_b", {32'h0, rdata_b[0]}, 64'h0);
      check_eq("f0_next_c", {32'h0, rdata_c[0]}, 64'h0);
      go_idle();
      check_eq("f0_dirty_a", dirty_a, 64'h0000_0003_0000_00A0);
      check_eq("f0_dirty_b", {32'h0, dirty_b}, 64'hA2);

      // x3 on port 0, 0x23 on port 1: separate words with FP bank, collision otherwise
      @(negedge clk);
      raddr[0] = 6'h03; raddr[1] = 6'h23; raddr[2] = 6'h05;
      waddr[0] = 6'h03; wdata[0] = 32'h33;
      waddr[1] = 6'h23; wdata[1] = 32'h44;
      we = 2'b11;
      #1;
      check_eq("x3_same_b", {32'h0, rdata_b[0]}, 64'h44);
      edge_sample();
      check_eq("x3_next_a", {32'h0, rdata_a[0]}, 64'h33);
      check_eq("f3_next_a", {32'h0, rdata_a[1]}, 64'h44);
      check_eq("x3_next_b", {32'h0, rdata_b[0]}, 64'h44);
      check_eq("x3_next_c", {32'h0, rdata_c[0]}, 64'h44);
      check_eq("x5_keep_a", {32'h0, rdata_a[2]}, 64'hDEADBEEF);
      check_eq("x5_keep_c", {32'h0, rdata_c[2]}, 64'hDEADBEEF);
      go_idle();
      check_eq("x3_dirty_a", dirty_a, 64'h0000_000B_0000_00A8);
      check_eq("x3_dirty_b", {32'h0, dirty_b}, 64'hAA);
      check_eq("x3_dirty_c", {32'h0, dirty_c}, 64'hAA);

      // Clear with a coincident x9 write leaves only bit 9
      @(negedge clk);
      raddr[0] = 6'd9;
      waddr[0] = 6'd9; wdata[0] = 32'h99;
      we = 2'b01;
      dirty_clr = 1'b1;
      edge_sample();
      check_eq("x9_next_a", {32'h0, rdata_a[0]}, 64'h99);
      go_idle();
      check_eq("clr_dirty_a", dirty_a, 64'h200);
      check_eq("clr_dirty_b", {32'h0, dirty_b}, 64'h200);
      check_eq("clr_dirty_c", {32'h0, dirty_c}, 64'h200);

      // Plain clear
      @(negedge clk);
      dirty_clr = 1'b1;
      edge_sample();
      go_idle();
      check_eq("clr2_dirty_a", dirty_a, 64'h0);
      check_eq("clr2_dirty_b", {32'h0, dirty_b}, 64'h0);
      check_eq("x9_hold_a", {32'h0, rdata_a[0]}, 64'h99);

      // Mid-cycle reset clears storage at once and blocks pending writes
      @(negedge clk);
      raddr[0] = 6'd5; raddr[1] = 6'd12;
      waddr[0] = 6'd12; wdata[0] = 32'h00C0FFEE;
      we = 2'b01;
      @(posedge clk);
      #2;
      check_eq("x12_pre_rst_a", {32'h0, rdata_a[1]}, 64'h00C0FFEE);
      rst_n = 1'b0;
      #1;
      check_eq("mrst_x5_a", {32'h0, rdata_a[0]}, 64'h0);
      check_eq("mrst_x5_c", {32'h0, rdata_c[0]}, 64'h0);
      check_eq("mrst_dirty_a", dirty_a, 64'h0);
      check_eq("mrst_dirty_b", {32'h0, dirty_b}, 64'h0);
      edge_sample();
      check_eq("mrst_x12_a", {32'h0, rdata_a[1]}, 64'h0);
      @(negedge clk);
      we    = 2'b00;
      rst_n = 1'b1;
      #1;
      check_eq("post_rst_x12_a", {32'h0, rdata_a[1]}, 64'h0);
      check_eq("post_rst_x12_b", {32'h0, rdata_b[1]}, 64'h0);
      check_eq("post_rst_x12_c", {32'h0, rdata_c[1]}, 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
